// File: rtl/ucie_ctl_sb_pkg.sv
// Shared constants for the UCIe sideband message builder: opcodes, header field
// offsets, default code tables and FSM state encoding.
package ucie_ctl_sb_pkg;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

  localparam int HDR_OPC_LSB  = 0;
  localparam int HDR_MSG_LSB  = 14;
  localparam int HDR_SRC_LSB  = 29;
  localparam int HDR_SUB_LSB  = 32;
  localparam int HDR_INFO_LSB = 40;
  localparam int HDR_DST_LSB  = 56;
  localparam int HDR_CP_BIT   = 62;
  localparam int HDR_DP_BIT   = 63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    TBL_MSG = 1'b0,
    TBL_SUB = 1'b1
  } tbl_sel_e;

  // Link-training defaults; element [0] is table entry 0.
  localparam logic [3:0][7:0] MSG_DEFAULTS = {8'h09, 8'h04, 8'h03, 8'h01};
  localparam logic [3:0][7:0] SUB_DEFAULTS = {8'h09, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] tbl_default(tbl_sel_e sel, int idx);
    if (idx > 3 || idx < 0) return 8'h00;
    return (sel == TBL_SUB) ? SUB_DEFAULTS[idx[1:0]] : MSG_DEFAULTS[idx[1:0]];
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_code_tbl.sv
// Code lookup table with async read and range flag. Writable registers when
// UCIE_CTL_SB_CFG_WR_EN is defined, otherwise constant link-training defaults.
module ucie_ctl_sb_code_tbl
  import ucie_ctl_sb_pkg::*;
#(
  parameter int       DEPTH = 4,
  parameter tbl_sel_e SEL   = TBL_MSG,
  parameter int       AW    = 2,
  parameter int       CAW   = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [AW-1:0]  i_rd_idx,
  output logic [7:0]     o_rd_code,
  output logic           o_rd_err,
  input  logic           i_wr_en,
  input  logic [CAW-1:0] i_wr_addr,
  input  logic [7:0]     i_wr_data
);

  logic [7:0] tbl [DEPTH];

`ifdef UCIE_CTL_SB_CFG_WR_EN
  // NOTE: the table is architectural state that must come back to its defaults,
  // so every entry is reset, unlike a plain data RAM.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= tbl_default(SEL, i);
    end else if (i_wr_en) begin
      for (int i = 0; i < DEPTH; i++)
        if (i_wr_addr == CAW'(i)) tbl[i] <= i_wr_data;
    end
  end
`else
  for (genvar g = 0; g < DEPTH; g++) begin : g_const
    assign tbl[g] = tbl_default(SEL, g);
  end

  logic unused_wr;
  assign unused_wr = ^{i_clk, i_rst, i_wr_en, i_wr_addr, i_wr_data};
`endif

  // NOTE: default first so an out-of-range index reads 00 instead of inferring a latch.
  always_comb begin
    o_rd_code = 8'h00;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_idx == AW'(i)) o_rd_code = tbl[i];
  end

  assign o_rd_err = ({1'b0, i_rd_idx} >= (AW+1)'(DEPTH));

endmodule

// File: rtl/ucie_ctl_sb_msg_builder.sv
// Sideband message builder: table lookup, header/parity assembly and a
// valid/ready beat stream. Optional table writes under UCIE_CTL_SB_CFG_WR_EN.
module ucie_ctl_sb_msg_builder
  import ucie_ctl_sb_pkg::*;
#(
  parameter int         MSG_DEPTH = 4,
  parameter int         SUB_DEPTH = 4,
  parameter logic [2:0] SRCID     = 3'b001,
  parameter logic [2:0] DSTID     = 3'b101,
  parameter int         CNT_W     = 16,
  localparam int        MIW       = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1,
  localparam int        SIW       = (SUB_DEPTH > 1) ? $clog2(SUB_DEPTH) : 1,
  localparam int        CAW       = (MIW > SIW) ? MIW : SIW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_with_data,
  input  logic [MIW-1:0]   i_req_msg_idx,
  input  logic [SIW-1:0]   i_req_sub_idx,
  input  logic [15:0]      i_req_info,
  input  logic [63:0]      i_req_data,
  output logic             o_pkt_valid,
  input  logic             i_pkt_ready,
  output logic [63:0]      o_pkt,
  output logic             o_pkt_last,
  output logic             o_idx_err,
  output logic [CNT_W-1:0] o_tx_cnt,
  input  logic             i_cfg_wr_en,
  input  logic             i_cfg_sel,
  input  logic [CAW-1:0]   i_cfg_addr,
  input  logic [7:0]       i_cfg_wdata
);

  state_e      state;
  logic [63:0] data_q;
  logic        with_data_q;
  logic [7:0]  msg_code, sub_code;
  logic        msg_err, sub_err;
  logic [63:0] hdr_next;

  ucie_ctl_sb_code_tbl #(.DEPTH(MSG_DEPTH), .SEL(TBL_MSG), .AW(MIW), .CAW(CAW)) u_msg_tbl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rd_idx  (i_req_msg_idx),
    .o_rd_code (msg_code),
    .o_rd_err  (msg_err),
    .i_wr_en   (i_cfg_wr_en && (i_cfg_sel == TBL_MSG)),
    .i_wr_addr (i_cfg_addr),
    .i_wr_data (i_cfg_wdata)
  );

  ucie_ctl_sb_code_tbl #(.DEPTH(SUB_DEPTH), .SEL(TBL_SUB), .AW(SIW), .CAW(CAW)) u_sub_tbl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rd_idx  (i_req_sub_idx),
    .o_rd_code (sub_code),
    .o_rd_err  (sub_err),
    .i_wr_en   (i_cfg_wr_en && (i_cfg_sel == TBL_SUB)),
    .i_wr_addr (i_cfg_addr),
    .i_wr_data (i_cfg_wdata)
  );

  // Header is built from the live request and the table reads, then frozen at accept.
  always_comb begin
    hdr_next = '0;
    hdr_next[HDR_OPC_LSB +: 5]   = i_req_with_data ? OPC_MSG_DATA : OPC_MSG_NODATA;
    hdr_next[HDR_MSG_LSB +: 8]   = msg_code;
    hdr_next[HDR_SRC_LSB +: 3]   = SRCID;
    hdr_next[HDR_SUB_LSB +: 8]   = sub_code;
    hdr_next[HDR_INFO_LSB +: 16] = i_req_info;
    hdr_next[HDR_DST_LSB +: 3]   = DSTID;
    hdr_next[HDR_CP_BIT]         = ^hdr_next[61:0];
    hdr_next[HDR_DP_BIT]         = i_req_with_data & (^i_req_data);
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      o_req_ready <= 1'b0;
      o_pkt_valid <= 1'b0;
      o_pkt       <= '0;
      o_pkt_last  <= 1'b0;
      o_idx_err   <= 1'b0;
      o_tx_cnt    <= '0;
      data_q      <= '0;
      with_data_q <= 1'b0;
    end else begin
      o_idx_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            state       <= ST_HDR;
            o_req_ready <= 1'b0;
            o_pkt_valid <= 1'b1;
            o_pkt       <= hdr_next;
            o_pkt_last  <= ~i_req_with_data;
            o_idx_err   <= msg_err | sub_err;
            data_q      <= i_req_data;
            with_data_q <= i_req_with_data;
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        ST_HDR: begin
          if (i_pkt_ready) begin
            if (with_data_q) begin
              state      <= ST_DATA;
              o_pkt      <= data_q;
              o_pkt_last <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              o_pkt_valid <= 1'b0;
              o_pkt_last  <= 1'b0;
              o_req_ready <= 1'b1;
              o_tx_cnt    <= o_tx_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (i_pkt_ready) begin
            state       <= ST_IDLE;
            o_pkt_valid <= 1'b0;
            o_pkt_last  <= 1'b0;
            o_req_ready <= 1'b1;
            o_tx_cnt    <= o_tx_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_pkt_valid <= 1'b0;
          o_pkt_last  <= 1'b0;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_sb_msg_builder.sv
// Directed bench for ucie_ctl_sb_msg_builder (MSG_DEPTH=5, CNT_W=3); adapts the
// table-write expectations to UCIE_CTL_SB_CFG_WR_EN.
module tb_ucie_ctl_sb_msg_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_with_data;
  logic [2:0]  req_msg_idx;
  logic [1:0]  req_sub_idx;
  logic [15:0] req_info;
  logic [63:0] req_data;
  logic        pkt_valid, pkt_ready, pkt_last, idx_err;
  logic [63:0] pkt;
  logic [2:0]  tx_cnt;
  logic        cfg_wr_en, cfg_sel;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [63:0] held;

  always #5 clk = ~clk;

  ucie_ctl_sb_msg_builder #(.MSG_DEPTH(5), .SUB_DEPTH(4), .CNT_W(3)) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_with_data (req_with_data),
    .i_req_msg_idx   (req_msg_idx),
    .i_req_sub_idx   (req_sub_idx),
    .i_req_info      (req_info),
    .i_req_data      (req_data),
    .o_pkt_valid     (pkt_valid),
    .i_pkt_ready     (pkt_ready),
    .o_pkt           (pkt),
    .o_pkt_last      (pkt_last),
    .o_idx_err       (idx_err),
    .o_tx_cnt        (tx_cnt),
    .i_cfg_wr_en     (cfg_wr_en),
    .i_cfg_sel       (cfg_sel),
    .i_cfg_addr      (cfg_addr),
    .i_cfg_wdata     (cfg_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_hdr(input logic wd, input logic [7:0] mc,
                                          input logic [7:0] sc, input logic [15:0] info,
                                          input logic dp);
    logic [63:0] h;
    h = '0;
    h[4:0]   = wd ? 5'b11011 : 5'b10010;
    h[21:14] = mc;
    h[31:29] = 3'b001;
    h[39:32] = sc;
    h[55:40] = info;
    h[58:56] = 3'b101;
    h[62]    = ^h[61:0];
    h[63]    = dp;
    return h;
  endfunction

  task automatic drive_req(input logic wd, input logic [2:0] mi, input logic [1:0] si,
                           input logic [15:0] info, input logic [63:0] data);
    req_valid = 1'b1; req_with_data = wd; req_msg_idx = mi;
    req_sub_idx = si; req_info = info; req_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_with_data = 1'b0; req_msg_idx = '0;
    req_sub_idx = '0; req_info = '0; req_data = '0; pkt_ready = 1'b1;
    cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_valid", {63'd0, pkt_valid}, 64'd0);
    check("rst_pkt", pkt, 64'd0);
    check("rst_cnt", {61'd0, tx_cnt}, 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // No-data request, msg 1 sub 2 info 0 (hand-computed header, cp=0)
    drive_req(1'b0, 3'd1, 2'd2, 16'h0000, 64'd0);
    tick();
    req_valid = 1'b0;
    check("t1_valid", {63'd0, pkt_valid}, 64'd1);
    check("t1_hdr", pkt, 64'h0500_0002_2000_C012);
    check("t1_opc", {59'd0, pkt[4:0]}, 64'h12);
    check("t1_last", {63'd0, pkt_last}, 64'd1);
    check("t1_ready_busy", {63'd0, req_ready}, 64'd0);
    check("t1_idx_err", {63'd0, idx_err}, 64'd0);
    tick();
    exp_cnt++;
    check("t1_done_valid", {63'd0, pkt_valid}, 64'd0);
    check("t1_cnt", {61'd0, tx_cnt}, 64'(exp_cnt));
    check("t1_ready", {63'd0, req_ready}, 64'd1);

    // With-data request, data=1 -> dp=1, cp=1 (hand-computed)
    drive_req(1'b1, 3'd0, 2'd0, 16'h1234, 64'h1);
    tick();
    req_valid = 1'b0;
    check("t2_hdr", pkt, 64'hC512_3400_2000_401B);
    check("t2_hdr_last", {63'd0, pkt_last}, 64'd0);
    tick();
    check("t2_data", pkt, 64'h1);
    check("t2_data_last", {63'd0, pkt_last}, 64'd1);
    check("t2_data_valid", {63'd0, pkt_valid}, 64'd1);
    tick();
    exp_cnt++;
    check("t2_done_valid", {63'd0, pkt_valid}, 64'd0);
    check("t2_cnt", {61'd0, tx_cnt}, 64'(exp_cnt % 8));

    // Backpressure: header held stable for 5 cycles
    pkt_ready = 1'b0;
    drive_req(1'b0, 3'd2, 2'd3, 16'hBEEF, 64'hFFFF_0000_FFFF_0000);
    tick();
    req_valid = 1'b0;
    req_msg_idx = 3'd0; req_info = 16'h0000;
    check("t3_hdr", pkt, exp_hdr(1'b0, 8'h04, 8'h09, 16'hBEEF, 1'b0));
    held = pkt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stable", pkt, held);
      check("t3_ready_low", {62'd0, req_ready, pkt_valid}, 64'd1);
    end
    pkt_ready = 1'b1;
    tick();
    exp_cnt++;
    check("t3_done_valid", {63'd0, pkt_valid}, 64'd0);
    check("t3_cnt", {61'd0, tx_cnt}, 64'(exp_cnt % 8));

    // Out-of-range index 6 (depth 5): code 00, 1-cycle error pulse
    drive_req(1'b0, 3'd6, 2'd1, 16'h00A5, 64'd0);
    tick();
    req_valid = 1'b0;
    check("t4_idx_err", {63'd0, idx_err}, 64'd1);
    check("t4_hdr", pkt, exp_hdr(1'b0, 8'h00, 8'h01, 16'h00A5, 1'b0));
    tick();
    exp_cnt++;
    check("t4_err_pulse", {63'd0, idx_err}, 64'd0);
    check("t4_cnt", {61'd0, tx_cnt}, 64'(exp_cnt % 8));
    // Last in-range entry (4) beyond the default list reads 00, no error
    drive_req(1'b0, 3'd4, 2'd3, 16'h0001, 64'd0);
    tick();
    req_valid = 1'b0;
    check("t4b_idx_err", {63'd0, idx_err}, 64'd0);
    check("t4b_hdr", pkt, exp_hdr(1'b0, 8'h00, 8'h09, 16'h0001, 1'b0));
    tick();
    exp_cnt++;

    // Table write in the same cycle as an accept: lookup sees the old value
    drive_req(1'b0, 3'd0, 2'd0, 16'h0000, 64'd0);
    cfg_wr_en = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'hA5;
    tick();
    req_valid = 1'b0; cfg_wr_en = 1'b0;
    check("t5_old_code", pkt, exp_hdr(1'b0, 8'h01, 8'h00, 16'h0000, 1'b0));
    tick();
    exp_cnt++;
    drive_req(1'b0, 3'd0, 2'd0, 16'h0000, 64'd0);
    tick();
    req_valid = 1'b0;
`ifdef UCIE_CTL_SB_CFG_WR_EN
    check("t5_new_code", pkt, exp_hdr(1'b0, 8'hA5, 8'h00, 16'h0000, 1'b0));
`else
    check("t5_const_code", pkt, exp_hdr(1'b0, 8'h01, 8'h00, 16'h0000, 1'b0));
`endif
    tick();
    exp_cnt++;
    check("t5_cnt", {61'd0, tx_cnt}, 64'(exp_cnt % 8));

    // Reset asserted during the data beat
    pkt_ready = 1'b0;
    drive_req(1'b1, 3'd3, 2'd3, 16'h5555, 64'hDEAD_BEEF_0123_4567);
    tick();
    req_valid = 1'b0;
    pkt_ready = 1'b1;
    tick();
    check("t6_in_data", pkt, 64'hDEAD_BEEF_0123_4567);
    check("t6_data_last", {63'd0, pkt_last}, 64'd1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("t6_rst_pkt", pkt, 64'd0);
    check("t6_rst_flags", {59'd0, pkt_valid, pkt_last, idx_err, req_ready, 1'b0}, 64'd0);
    check("t6_rst_cnt", {61'd0, tx_cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_ready", {63'd0, req_ready}, 64'd1);
    drive_req(1'b0, 3'd0, 2'd0, 16'h0000, 64'd0);
    tick();
    req_valid = 1'b0;
    check("t6_tbl_default", pkt, exp_hdr(1'b0, 8'h01, 8'h00, 16'h0000, 1'b0));
    tick();
    exp_cnt++;
    check("t6_cnt", {61'd0, tx_cnt}, 64'(exp_cnt));

    // Counter wrap: 3-bit counter goes 7 -> 0
    for (int i = 0; i < 7; i++) begin
      drive_req(1'b0, 3'(i % 5), 2'(i % 4), 16'(i), 64'd0);
      tick();
      req_valid = 1'b0;
      tick();
      exp_cnt++;
      check("wrap_cnt", {61'd0, tx_cnt}, 64'(exp_cnt % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
